regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide ports rs_addr, rt_addr  in  5  read-port source register numbers.
REQ-004 SHALL provide ports rs_data, rt_data  out  32  read-port data.
REQ-005 SHALL provide ports rs_busy, rt_busy  out  1  addressed register has an outstanding write.
REQ-006 SHALL provide port rd_req  in  1  decode stage consumes rs/rt this cycle.
REQ-007 SHALL provide port stall  out  1  decode must hold; issue blocked.
REQ-008 SHALL provide ports iss_en  in  1, iss_addr  in  5  instruction issued that will write iss_addr.
REQ-009 SHALL provide ports wr_en  in  1, wr_addr  in  5, wr_data  in  32  write-back port; wr_addr is the RegDst-selected destination (rd or rt).
REQ-010 SHALL provide port pend_cnt  out  6  number of registers currently busy (0..31).
REQ-011 SHALL provide port idle  out  1  pend_cnt == 0.

Function
REQ-012 SHALL hold 32 x 32-bit registers; register 0 reads 0, ignores writes, never busy.
REQ-013 SHALL write wr_data to wr_addr at rising edge when wr_en=1 and wr_addr!=0.
REQ-014 SHALL drive rs_data/rt_data and rs_busy/rt_busy combinationally from current state and addresses (zero-cycle read latency).
REQ-015 SHALL drive stall = rd_req & (rs_busy | rt_busy), combinational.
REQ-016 SHALL set busy[iss_addr] at rising edge when iss_en=1, iss_addr!=0, stall=0; iss_en while stall=1 is ignored.
REQ-017 SHALL clear busy[wr_addr] at rising edge when wr_en=1 and wr_addr!=0.
REQ-018 SHALL, on same-edge set and clear of the same register, leave it busy (newer producer wins); pend_cnt unchanged.
REQ-019 SHALL, on set and clear of different registers in one edge, leave pend_cnt unchanged.
REQ-020 SHALL increment pend_cnt only on a 0->1 busy transition and decrement only on 1->0; setting an already-busy register or clearing an idle one does not change pend_cnt; no wrap beyond 0 or 31.
REQ-021 SHALL accept a wr_en to a non-busy register as an ordinary write (no error, no count change).

Reset
REQ-022 SHALL, while rst_n=0, asynchronously clear all 32 registers to 0, all busy bits to 0, pend_cnt to 0.
REQ-023 SHALL output after reset: rs_data=rt_data=0, rs_busy=rt_busy=0, stall=0, pend_cnt=0, idle=1.
REQ-024 SHALL discard any in-flight issue/write coincident with reset assertion; first update on first rising edge with rst_n=1.

Configuration
REQ-025 SHALL compile write-to-read bypass only when macro REGFILE_SB_BYPASS_EN is defined.
REQ-026 With REGFILE_SB_BYPASS_EN: when wr_en=1, wr_addr!=0 and wr_addr equals a read address, that port returns wr_data and reports busy=0 in the same cycle (stall computed from bypassed busy).
REQ-027 Without REGFILE_SB_BYPASS_EN: reads return pre-write array value and busy stays 1 until the edge after write-back.

Verification
REQ-028 Reset: rst_n=0 mid-operation with pend_cnt=3 -> pend_cnt=0, idle=1, rs_data=0 immediately, without clock edge.
REQ-029 Write/read: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, next cycle rs_addr=5 -> rs_data=0xDEADBEEF; write to reg 0 -> reads 0.
REQ-030 Hazard: iss_en=1 iss_addr=8; next cycle rd_req=1 rt_addr=8 -> stall=1, pend_cnt=1; later wr_en wr_addr=8 -> stall=0 next cycle (same cycle if BYPASS_EN), pend_cnt=0.
REQ-031 Collision: busy[9]=1, same edge iss_en iss_addr=9 and wr_en wr_addr=9 -> busy[9]=1, pend_cnt unchanged.
REQ-032 Blocked issue: stall=1 with iss_en=1 iss_addr=12 -> busy[12] stays 0, pend_cnt unchanged.
REQ-033 Fill: issue to registers 1..31 with no write-back -> pend_cnt=31; re-issue to 1 -> pend_cnt stays 31; issue to 0 -> no change.

Source files
------------

// File: rtl/regfile_sb.sv
// 32x32 register file with per-register busy scoreboard for issue/write-back hazard tracking.
// Optional same-cycle write-to-read bypass is compiled in with REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              rd_req,
  output logic              stall,
  input  logic              iss_en,
  input  logic [4:0]        iss_addr,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [5:0]        pend_cnt,
  output logic              idle
);

  logic [DATA_W-1:0] regs [32];
  logic [31:0]       busy;
  logic [31:0]       busy_nxt;
  logic [5:0]        cnt_nxt;
  logic              wr_hit;
  logic              iss_hit;
  logic              set_new;
  logic              clr_real;

  // Saturating +1/-1 step; the counter tracks popcount(busy) so it stays in 0..31.
  function automatic logic [5:0] cnt_step(input logic [5:0] cnt, input logic inc, input logic dec);
    logic [5:0] r;
    r = cnt;
    if (inc && !dec && cnt != 6'd31)
      r = cnt + 6'd1;
    else if (dec && !inc && cnt != 6'd0)
      r = cnt - 6'd1;
    return r;
  endfunction

  assign wr_hit = wr_en & (wr_addr != 5'd0);

`ifdef REGFILE_SB_BYPASS_EN
  logic rs_byp;
  logic rt_byp;
  assign rs_byp  = wr_hit & (wr_addr == rs_addr);
  assign rt_byp  = wr_hit & (wr_addr == rt_addr);
  assign rs_data = rs_byp ? wr_data : regs[rs_addr];
  assign rt_data = rt_byp ? wr_data : regs[rt_addr];
  assign rs_busy = busy[rs_addr] & ~rs_byp;
  assign rt_busy = busy[rt_addr] & ~rt_byp;
`else
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];
  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];
`endif

  assign stall   = rd_req & (rs_busy | rt_busy);
  assign iss_hit = iss_en & (iss_addr != 5'd0) & ~stall;

  // A clear that collides with a new issue to the same register is overridden by the issue.
  assign set_new  = iss_hit & ~busy[iss_addr];
  assign clr_real = wr_hit & busy[wr_addr] & ~(iss_hit & (iss_addr == wr_addr));

  always_comb begin
    busy_nxt = busy;
    if (wr_hit)
      busy_nxt[wr_addr] = 1'b0;
    if (iss_hit)
      busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = cnt_step(pend_cnt, set_new, clr_real);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign idle = (pend_cnt == 6'd0);

endmodule
